// File: rtl/plasma_gpio_debounce.sv
// Board I/O conditioner: synchronise and debounce raw inputs, sticky rising-edge events,
// maskable level irq and registered outputs. Edge events/irq exist only with GPIO_EDGE_IRQ_EN defined.
module plasma_gpio_debounce #(
  parameter int                   IN_WIDTH        = 13,
  parameter int                   OUT_WIDTH       = 13,
  parameter int                   SYNC_STAGES     = 2,
  parameter int                   DEBOUNCE_CYCLES = 500000,
  parameter int                   CNT_WIDTH       = 20,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  raw_i,
  output logic [OUT_WIDTH-1:0] out_o,
  input  logic [1:0]           reg_sel,
  input  logic                 wr_en,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  output logic                 irq_o
);

  // Register port: no handshake. A write is accepted on every cycle wr_en is high;
  // rd_data always shows the register selected by reg_sel on the previous cycle.
  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_EVENT = 2'd1;
  localparam logic [1:0] REG_OUT   = 2'd2;
  localparam logic [1:0] REG_MASK  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [IN_WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0]  sync_n;
  logic [IN_WIDTH-1:0]  stable_q;
  logic [IN_WIDTH-1:0]  accept;
  logic [IN_WIDTH-1:0]  rise;
  logic [CNT_WIDTH-1:0] cnt_q [IN_WIDTH];
  logic [OUT_WIDTH-1:0] out_q;
  logic [IN_WIDTH-1:0]  event_q;
  logic [IN_WIDTH-1:0]  mask_q;
  logic                 irq_q;
  logic [31:0]          rd_next;
  logic [31:0]          rd_q;
  logic                 unused_sink;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_n = sync_q[SYNC_STAGES-1];

  // A channel flips only after its synchronised value has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    accept = '0;
    for (int i = 0; i < IN_WIDTH; i++)
      accept[i] = (sync_n[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
  end

  assign rise = accept & sync_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < IN_WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (sync_n[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          stable_q[i] <= sync_n[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              out_q <= OUT_RESET;
    else if (wr_en && reg_sel == REG_OUT)   out_q <= wr_data[OUT_WIDTH-1:0];
  end

`ifdef GPIO_EDGE_IRQ_EN
  logic [IN_WIDTH-1:0] clear;

  assign clear = (wr_en && reg_sel == REG_EVENT) ? wr_data[IN_WIDTH-1:0] : '0;

  // A new edge is ORed in after the W1C clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= '0;
      mask_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      event_q <= (event_q & ~clear) | rise;
      if (wr_en && reg_sel == REG_MASK) mask_q <= wr_data[IN_WIDTH-1:0];
      irq_q <= |(event_q & mask_q);
    end
  end

  assign unused_sink = ^wr_data;
`else
  assign event_q     = '0;
  assign mask_q      = '0;
  assign irq_q       = 1'b0;
  assign unused_sink = ^{wr_data, rise};
`endif

  always_comb begin
    rd_next = '0;
    case (reg_sel)
      REG_STATE: rd_next[IN_WIDTH-1:0]  = stable_q;
      REG_EVENT: rd_next[IN_WIDTH-1:0]  = event_q;
      REG_OUT:   rd_next[OUT_WIDTH-1:0] = out_q;
      default:   rd_next[IN_WIDTH-1:0]  = mask_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_next;
  end

  assign out_o   = out_q;
  assign rd_data = rd_q;
  assign irq_o   = irq_q;

endmodule
